// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, IF/ID register, JR/JAL/branch redirects and single-shot EXEC.
// Optional flush-cycle counter is built when FETCH_FLUSH_CNT_EN is defined.
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Exec,
    input  logic [11:0] Imm,
    input  logic [15:0] RegTarget,
    input  logic [15:0] ExecAddr,
    input  logic [15:0] ImemData,
    output logic [15:0] ImemAddr,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic [15:0] PCPlus1,
    output logic        ExecActive,
    output logic [15:0] FlushCount
);

    typedef enum logic [1:0] {RUN, EXEC_FETCH, EXEC_RET} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] id_pc;
    logic [15:0] ret_pc;
    logic [15:0] ret_pc_next;
    logic [15:0] instr_next;
    logic [15:0] seq_pc;
    logic [15:0] br_target;
    logic [15:0] jal_target;
    logic        valid_next;
    logic        exec_active_next;
    logic        redirect;

    always_comb begin
        seq_pc           = id_pc + 16'd1;
        br_target        = seq_pc + {{8{Imm[7]}}, Imm[7:0]};
        jal_target       = seq_pc + {{4{Imm[11]}}, Imm};
        pc_next          = pc + 16'd1;
        instr_next       = ImemData;
        valid_next       = 1'b1;
        exec_active_next = ExecActive;
        ret_pc_next      = ret_pc;
        state_next       = state;
        redirect         = 1'b0;

        case (state)
            EXEC_FETCH: begin
                pc_next          = ret_pc;
                exec_active_next = 1'b1;
                state_next       = EXEC_RET;
            end
            EXEC_RET: begin
                exec_active_next = 1'b0;
                state_next       = RUN;
            end
            default: ;
        endcase

        // A control transfer from the EXEC'd instruction overrides the pending return.
        if (InstrValid) begin
            if (Jr || Jal || BranchTaken) begin
                redirect         = 1'b1;
                pc_next          = Jr ? RegTarget : (Jal ? jal_target : br_target);
                exec_active_next = 1'b0;
                state_next       = RUN;
            end else if (Exec && !ExecActive) begin
                redirect    = 1'b1;
                pc_next     = ExecAddr;
                ret_pc_next = seq_pc;
                state_next  = EXEC_FETCH;
            end
        end

        if (redirect) begin
            instr_next = '0;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= '0;
            id_pc      <= '0;
            ret_pc     <= '0;
            Instr      <= '0;
            InstrValid <= 1'b0;
            ExecActive <= 1'b0;
        end else if (!Stall) begin
            state      <= state_next;
            pc         <= pc_next;
            id_pc      <= pc;
            ret_pc     <= ret_pc_next;
            Instr      <= instr_next;
            InstrValid <= valid_next;
            ExecActive <= exec_active_next;
        end
    end

    assign ImemAddr = pc;
    assign PCPlus1  = seq_pc;

`ifdef FETCH_FLUSH_CNT_EN
    logic [15:0] flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count <= '0;
        end else if (!Stall && redirect && (flush_count != '1)) begin
            flush_count <= flush_count + 16'd1;
        end
    end

    assign FlushCount = flush_count;
`else
    assign FlushCount = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all other ports are listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 Stall  input  1  hold all registers this cycle (hazard stall from decode).
REQ-005 BranchTaken  input  1  taken conditional branch for the instruction in Instr.
REQ-006 Jal  input  1  JAL for the instruction in Instr.
REQ-007 Jr  input  1  JR for the instruction in Instr.
REQ-008 Exec  input  1  EXEC for the instruction in Instr.
REQ-009 Imm  input  12  Instr[11:0]; branch uses Imm[7:0], JAL uses Imm[11:0], both sign-extended.
REQ-010 RegTarget  input  16  Rs value for JR.
REQ-011 ExecAddr  input  16  Rs value for EXEC.
REQ-012 ImemData  input  16  instruction memory read data, combinational in ImemAddr.
REQ-013 ImemAddr  output  16  fetch address, equals the PC register.
REQ-014 Instr  output  16  IF/ID instruction register.
REQ-015 InstrValid  output  1  Instr holds a real instruction (0 = flushed bubble).
REQ-016 PCPlus1  output  16  IdPC+1, the JAL link value.
REQ-017 ExecActive  output  1  Instr holds the single instruction fetched on behalf of EXEC.
REQ-018 FlushCount  output  16  count of flush cycles (see Configuration).

Function
REQ-019 Fetch latency SHALL be one cycle: on each unstalled edge, Instr<=ImemData, IdPC<=PC, InstrValid<=1, unless a redirect occurs.
REQ-020 Redirects SHALL be evaluated only when Stall=0 and InstrValid=1, with priority Jr > Jal > BranchTaken > Exec.
REQ-021 The targets SHALL be: JR = RegTarget; JAL = IdPC+1+sext(Imm[11:0]); branch = IdPC+1+sext(Imm[7:0]); EXEC = ExecAddr. All use modulo-2^16 arithmetic, so 0xFFFF+1 wraps to 0x0000.
REQ-022 On a redirect, PC<=target and Instr<=16'h0000 with InstrValid<=0: a one-cycle bubble that discards the wrong-path fetch.
REQ-023 Without a redirect, PC<=PC+1.
REQ-024 The FSM SHALL have states RUN, EXEC_FETCH and EXEC_RET.
  - RUN: on Exec with no higher redirect, set RetPC<=IdPC+1 and go to EXEC_FETCH.
  - EXEC_FETCH: load Instr from ExecAddr normally, set ExecActive<=1, PC<=RetPC, then go to EXEC_RET.
  - EXEC_RET: ExecActive<=0 on the next unstalled load, then go to RUN.
REQ-025 Exec asserted while ExecActive=1 (nested EXEC) SHALL be ignored, with no redirect.
REQ-026 A Jr, Jal or BranchTaken redirect from the EXEC'd instruction SHALL win: discard RetPC, clear ExecActive, return to RUN.
REQ-027 Stall=1 SHALL freeze PC, Instr, IdPC, InstrValid, state, RetPC and ExecActive; ImemAddr is unchanged.
REQ-028 Redirect inputs SHALL be ignored when InstrValid=0.

Reset
REQ-029 Reset SHALL set PC=0, IdPC=0, Instr=16'h0000, InstrValid=0, ExecActive=0, RetPC=0, state=RUN and FlushCount=0, asynchronously.
REQ-030 After deassertion, the first edge SHALL fetch address 0.
REQ-031 Reset mid-EXEC SHALL abandon the EXEC with no return.

Configuration
REQ-032 With FETCH_FLUSH_CNT_EN defined, FlushCount SHALL increment by one (saturating at 0xFFFF) on every edge that performs a redirect.
REQ-033 Without FETCH_FLUSH_CNT_EN, FlushCount SHALL be constant 0 and no counter register is built.

Verification
REQ-034 Release reset with memory word n = 16'h1000+n, no redirects -> ImemAddr 0,1,2,3; Instr 0x1000,0x1001,… one cycle later; InstrValid=1 from the first edge.
REQ-035 BranchTaken=1, Imm[7:0]=0xFE, IdPC=0x0010 -> next PC=0x000F; Instr=0x0000 with InstrValid=0 for one cycle; with FETCH_FLUSH_CNT_EN, FlushCount=1.
REQ-036 Jr=1 and BranchTaken=1 together, RegTarget=0x0200 -> PC=0x0200 (JR priority); Jal, Imm=0x800, IdPC=0x0005 -> PC=0xF806, PCPlus1=0x0006.
REQ-037 Exec=1, ExecAddr=0x0040, IdPC=0x0020 -> bubble, then Instr=mem[0x40] with ExecActive=1, then fetch resumes at 0x0021; nested Exec during ExecActive is ignored.
REQ-038 Stall held for 3 cycles during an EXEC_FETCH -> all outputs frozen, sequence resumes intact; rst asserted mid-EXEC -> all outputs at reset values immediately.
